sram_like_arbiter: RTL

- Shares one downstream SRAM-like memory port between the CPU instruction port and data port.
- Sits between the pipeline top's inst_*/data_* SRAM-like outputs and the single cache/bridge port.
- Arbitrates request issue with fixed data priority and locks the grant until addr_ok.
- Tracks the owner of each outstanding transaction in an in-order FIFO and routes each data_ok back to its requester.

---
 rtl/sram_like_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// Shares one downstream SRAM-like memory port between the CPU instruction
// port and data port. Request issue uses fixed data priority. Once a request
// has been presented without addr_ok, the grant stays with that requester
// until it is accepted. An in-order owner FIFO records who issued each
// accepted transaction, so every data_ok is routed back to its requester.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   inst_* (in)         : instruction requester req/wr/size/addr/wdata
//   inst_* (out)        : instruction addr_ok, data_ok, rdata
//   data_* (in)         : data requester req/wr/size/addr/wdata
//   data_* (out)        : data addr_ok, data_ok, rdata
//   mem_*  (out)        : downstream req/wr/size/addr/wdata
//   mem_*  (in)         : downstream addr_ok, data_ok, rdata
module sram_like_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_LOCK_I = 2'd1,
      ST_LOCK_D = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [CNT_W-1:0]   r_count;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic               r_owner [DEPTH];   // 0 = inst, 1 = data

   logic               w_full;
   logic               w_sel_data;
   logic               w_mem_req;
   logic               w_push;
   logic               w_pop;
   logic               w_head_data;

   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_head_data = r_owner[r_rd_ptr];

   // ------------------------------------------------------------------
   // Grant FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_FREE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_sel_data   = 1'b0;
      w_mem_req    = 1'b0;
      case (r_state)
         ST_FREE: begin
            w_sel_data = data_req;
            w_mem_req  = (inst_req | data_req) & ~w_full;
            // A request left hanging pins the grant to its owner so the
            // payload seen downstream cannot switch before addr_ok.
            if (w_mem_req && !mem_addr_ok) begin
               w_state_next = w_sel_data ? ST_LOCK_D : ST_LOCK_I;
            end
         end
         ST_LOCK_I: begin
            w_sel_data = 1'b0;
            w_mem_req  = inst_req;
            // Owner dropping req is a protocol violation; release quietly.
            if (!inst_req || mem_addr_ok) begin
               w_state_next = ST_FREE;
            end
         end
         ST_LOCK_D: begin
            w_sel_data = 1'b1;
            w_mem_req  = data_req;
            if (!data_req || mem_addr_ok) begin
               w_state_next = ST_FREE;
            end
         end
         default: begin
            w_state_next = ST_FREE;
         end
      endcase
      if (rst) begin
         w_mem_req = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Owner FIFO
   // ------------------------------------------------------------------
   // A lock is only entered while not full and pops can only free space,
   // so a push at lock release never overflows.
   assign w_push = w_mem_req & mem_addr_ok;
   assign w_pop  = mem_data_ok & (r_count != '0) & ~rst;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_owner
         always_ff @(posedge clk) begin
            if (rst) begin
               r_owner[gi] <= 1'b0;
            end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
               r_owner[gi] <= w_sel_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Downstream payload and upstream acknowledge routing
   // ------------------------------------------------------------------
   assign mem_req   = w_mem_req;
   assign mem_wr    = w_sel_data ? data_wr    : inst_wr;
   assign mem_size  = w_sel_data ? data_size  : inst_size;
   assign mem_addr  = w_sel_data ? data_addr  : inst_addr;
   assign mem_wdata = w_sel_data ? data_wdata : inst_wdata;

   assign inst_addr_ok = w_push & ~w_sel_data;
   assign data_addr_ok = w_push &  w_sel_data;

   assign inst_data_ok = w_pop & ~w_head_data;
   assign data_data_ok = w_pop &  w_head_data;

   assign inst_rdata = mem_rdata;
   assign data_rdata = mem_rdata;

endmodule
